// File: rtl/i2s_dac_tx.sv
// Serial DAC output stage: offset-binary mono samples in, 3-wire I2S-style stereo stream out.
// Define I2S_DELAY_EN for the standard one-bit I2S data delay; left-justified otherwise.
module i2s_dac_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        sample_tick,
  output logic        underrun
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(BCLK_DIV);

  logic [CNT_W-1:0]         div_cnt;
  logic [4:0]               slot;
  logic signed [DATA_W-1:0] hold;
  logic                     full;
  logic [2*DATA_W-1:0]      frame_word;

  logic                div_wrap;
  logic                fall;
  logic                load;
  logic                accept;
  logic [4:0]          slot_nxt;
  logic [2*DATA_W-1:0] frame_nxt;
  logic                sdata_nxt;

  function automatic logic signed [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] ob);
    return {~ob[DATA_W-1], ob[DATA_W-2:0]};
  endfunction

  assign div_wrap     = (div_cnt == CNT_W'(BCLK_DIV - 1));
  assign fall         = div_wrap & i2s_bclk;
  assign slot_nxt     = slot + 5'd1;
  assign load         = fall & (slot == 5'd31);
  assign accept       = sample_valid & ~full;
  assign sample_ready = ~full;

  always_comb begin
    frame_nxt = frame_word;
    if (load && full)
      frame_nxt = {hold, hold};
`ifdef I2S_DELAY_EN
    // Slot 0 finishes the outgoing word's LSB; slot k>=1 carries bit 32-k.
    if (slot_nxt == 5'd0)
      sdata_nxt = frame_word[0];
    else
      sdata_nxt = frame_nxt[5'd31 - slot];
`else
    sdata_nxt = frame_nxt[5'd31 - slot_nxt];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      slot        <= '0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_word  <= '0;
      hold        <= '0;
      full        <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= load;
      underrun    <= load & ~full;
      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      // Serial outputs move only on bclk falling events so they are stable at every rising edge.
      if (fall) begin
        slot       <= slot_nxt;
        i2s_lrclk  <= slot_nxt[4];
        i2s_sdata  <= sdata_nxt;
        frame_word <= frame_nxt;
      end
      // A load with full=1 and an accept are mutually exclusive (accept needs full=0).
      if (load && full) begin
        full <= 1'b0;
      end else if (accept) begin
        full <= 1'b1;
        hold <= to_twos(sample_in);
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomized self-checking bench for i2s_dac_tx: two instances (BCLK_DIV=4 and 2) against a frame-level model.
module tb_i2s_dac_tx;

  localparam int DIVS [2] = '{4, 2};

  logic        clk = 1'b0;
  logic        reset;
  logic        vld  [2];
  logic [15:0] smp  [2];
  logic        rdy  [2];
  logic        bclk [2];
  logic        lrck [2];
  logic        sdat [2];
  logic        tick [2];
  logic        undr [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edge count since release, current/previous frame word, holding entry.
  int          cnt    [2];
  logic [31:0] m_word [2];
  logic [31:0] m_prev [2];
  bit          m_full [2];
  logic [15:0] m_hold [2];
  bit          m_tick [2];
  bit          m_und  [2];
  bit          sent   [2];
  int          last_f [2];
  logic [15:0] bp_cnt [2];

  always #5 clk = ~clk;

  i2s_dac_tx #(.BCLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .sample_in(smp[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .i2s_bclk(bclk[0]), .i2s_lrclk(lrck[0]),
    .i2s_sdata(sdat[0]), .sample_tick(tick[0]), .underrun(undr[0])
  );

  i2s_dac_tx #(.BCLK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .sample_in(smp[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .i2s_bclk(bclk[1]), .i2s_lrclk(lrck[1]),
    .i2s_sdata(sdat[1]), .sample_tick(tick[1]), .underrun(undr[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    cnt[i]    = 0;
    m_word[i] = '0;
    m_prev[i] = '0;
    m_full[i] = 0;
    m_hold[i] = '0;
    m_tick[i] = 0;
    m_und[i]  = 0;
    sent[i]   = 0;
    last_f[i] = -1;
  endtask

  task automatic model_step(input int i);
    bit load;
    bit acc;
    cnt[i]++;
    load = (cnt[i] % (64 * DIVS[i])) == 0;
    acc  = vld[i] && !m_full[i];
    m_tick[i] = load;
    m_und[i]  = load && !m_full[i];
    if (load) begin
      m_prev[i] = m_word[i];
      if (m_full[i]) begin
        m_word[i] = {m_hold[i], m_hold[i]};
        m_full[i] = 0;
      end
    end
    if (acc) begin
      m_hold[i] = smp[i] ^ 16'h8000;
      m_full[i] = 1;
      sent[i]   = 1;
      bp_cnt[i] = bp_cnt[i] + 16'd1;
    end
  endtask

  task automatic compare(input int i);
    int  d;
    int  slot;
    logic exp_sd;
    d    = DIVS[i];
    slot = (cnt[i] / (2 * d)) % 32;
`ifdef I2S_DELAY_EN
    exp_sd = (slot == 0) ? m_prev[i][0] : m_word[i][32 - slot];
`else
    exp_sd = m_word[i][31 - slot];
`endif
    check($sformatf("bclk%0d", i),  {31'd0, bclk[i]}, ((cnt[i] / d) % 2));
    check($sformatf("lrclk%0d", i), {31'd0, lrck[i]}, {31'd0, (slot >= 16)});
    check($sformatf("sdata%0d", i), {31'd0, sdat[i]}, {31'd0, exp_sd});
    check($sformatf("ready%0d", i), {31'd0, rdy[i]},  {31'd0, !m_full[i]});
    check($sformatf("tick%0d", i),  {31'd0, tick[i]}, {31'd0, m_tick[i]});
    check($sformatf("under%0d", i), {31'd0, undr[i]}, {31'd0, m_und[i]});
  endtask

  // Per-frame stimulus schedule: directed conversion/underrun frames, then backpressure, then random.
  task automatic drive(input int i);
    int f;
    f = cnt[i] / (64 * DIVS[i]);
    if (f != last_f[i]) begin
      sent[i]   = 0;
      last_f[i] = f;
    end
    case (f)
      0:       begin smp[i] = 16'hC000; vld[i] = !sent[i]; end
      1:       begin smp[i] = 16'hFFFF; vld[i] = !sent[i]; end
      2:       begin smp[i] = 16'h5A5A; vld[i] = 1'b0;     end
      3:       begin smp[i] = 16'h0000; vld[i] = !sent[i]; end
      4, 5:    begin smp[i] = bp_cnt[i]; vld[i] = 1'b1;    end
      default: begin smp[i] = 16'($urandom); vld[i] = ($urandom_range(0, 63) == 0); end
    endcase
  endtask

  task automatic step_all();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      compare(i);
      drive(i);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i]    = 1'b0;
      smp[i]    = 16'h8000;
      bp_cnt[i] = 16'h1234;
      model_reset(i);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) drive(i);

    // Run into frame 5 (backpressure, holding register full) and stop at slot 10.
    while (cnt[0] < 5 * 256 + 10 * 8 + 3) step_all();
    check("full_before_reset", {31'd0, rdy[0]}, 32'd0);

    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      compare(i);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) drive(i);

    while (cnt[0] < 8 * 256) step_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
